// File: rtl/neokeon_round_ctrl.sv
// neokeon_round_ctrl
//   Round sequencer for a NOEKEON-style block cipher datapath. After a start
//   request it issues a 1-cycle load, 16 rounds, a 1-cycle final transform and
//   a 1-cycle done pulse, and feeds the key register the round-constant
//   sequence (encrypt: doubling in GF(2^8), decrypt: the inverse walk).
//
//   Optional feature macro: NEOKEON_DECRYPT_EN
//     defined   -> inDecrypt is honoured and decrypt constants are generated
//     undefined -> encrypt only, inDecrypt ignored, outDecMode tied to 0
//
// Ports
//   inClk        system clock, rising edge
//   inRst        asynchronous active-high reset
//   inStart      start request, level sampled, accepted only in IDLE
//   inDecrypt    mode select sampled on start acceptance (1 = decrypt)
//   inKeyWr      request to write a new main key
//   outExtWr     key-register external write strobe (combinational, IDLE only)
//   outIntWr     key-register round-constant write strobe
//   outIntRC     round constant {24'h0, rc}
//   outLoadData  state register loads the input block
//   outRoundEn   datapath executes one full round
//   outFinal     datapath executes the final output transform
//   outRound     round index 0..16
//   outDecMode   latched mode
//   outBusy      high in every state except IDLE
//   outDone      one-cycle completion pulse
//   outKeyErr    one-cycle pulse: key write request dropped while busy
module neokeon_round_ctrl (
    input  logic        inClk,
    input  logic        inRst,
    input  logic        inStart,
    input  logic        inDecrypt,
    input  logic        inKeyWr,
    output logic        outExtWr,
    output logic        outIntWr,
    output logic [31:0] outIntRC,
    output logic        outLoadData,
    output logic        outRoundEn,
    output logic        outFinal,
    output logic [4:0]  outRound,
    output logic        outDecMode,
    output logic        outBusy,
    output logic        outDone,
    output logic        outKeyErr
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    state_t     state;
    logic [7:0] rc;
    logic       start_dec;

    function automatic logic [7:0] enc_step(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

`ifdef NEOKEON_DECRYPT_EN
    logic dec_mode;

    function automatic logic [7:0] dec_step(input logic [7:0] r);
        return {1'b0, r[7:1]} ^ (r[0] ? 8'h8D : 8'h00);
    endfunction

    function automatic logic [7:0] rc_step(input logic [7:0] r, input logic dec);
        return dec ? dec_step(r) : enc_step(r);
    endfunction

    assign start_dec  = inDecrypt;
    assign outDecMode = dec_mode;
`else
    logic unused_decrypt;

    function automatic logic [7:0] rc_step(input logic [7:0] r, input logic dec);
        return dec ? enc_step(r) : enc_step(r);
    endfunction

    assign unused_decrypt = inDecrypt;
    assign start_dec      = 1'b0;
    assign outDecMode     = 1'b0;
`endif

    // Key writes bypass the FSM so the key register sees them in the same
    // cycle; gated by reset so every strobe reads zero while reset is held.
    assign outExtWr = ~inRst & (state == IDLE) & inKeyWr;
    assign outIntRC = {24'h0, rc};

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            state       <= IDLE;
            rc          <= 8'h80;
            outRound    <= '0;
            outIntWr    <= 1'b0;
            outLoadData <= 1'b0;
            outRoundEn  <= 1'b0;
            outFinal    <= 1'b0;
            outBusy     <= 1'b0;
            outDone     <= 1'b0;
            outKeyErr   <= 1'b0;
`ifdef NEOKEON_DECRYPT_EN
            dec_mode    <= 1'b0;
`endif
        end else begin
            outIntWr    <= 1'b0;
            outLoadData <= 1'b0;
            outRoundEn  <= 1'b0;
            outFinal    <= 1'b0;
            outDone     <= 1'b0;
            outKeyErr   <= outBusy & inKeyWr;
            case (state)
                IDLE: begin
                    if (inStart && !inKeyWr) begin
                        state       <= LOAD;
                        rc          <= start_dec ? 8'hD4 : 8'h80;
                        outRound    <= '0;
                        outLoadData <= 1'b1;
                        outIntWr    <= 1'b1;
                        outBusy     <= 1'b1;
`ifdef NEOKEON_DECRYPT_EN
                        dec_mode    <= start_dec;
`endif
                    end
                end
                LOAD: begin
                    state      <= ROUND;
                    rc         <= rc_step(rc, outDecMode);
                    outRoundEn <= 1'b1;
                    outIntWr   <= 1'b1;
                end
                ROUND: begin
                    if (outRound == 5'd15) begin
                        state    <= FINAL;
                        outRound <= 5'd16;
                        outFinal <= 1'b1;
                    end else begin
                        rc         <= rc_step(rc, outDecMode);
                        outRound   <= outRound + 5'd1;
                        outRoundEn <= 1'b1;
                        outIntWr   <= 1'b1;
                    end
                end
                FINAL: begin
                    state   <= DONE;
                    outDone <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    outRound <= '0;
                    outBusy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    outRound <= '0;
                    outBusy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neokeon_round_ctrl.sv
module tb_neokeon_round_ctrl;

    logic        inClk = 1'b0;
    logic        inRst, inStart, inDecrypt, inKeyWr;
    logic        outExtWr, outIntWr, outLoadData, outRoundEn, outFinal;
    logic [31:0] outIntRC;
    logic [4:0]  outRound;
    logic        outDecMode, outBusy, outDone, outKeyErr;

    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef NEOKEON_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef struct packed {
        logic        ext, intwr, load, rnd, fin, done, busy, kerr, decm;
        logic [4:0]  round;
        logic [31:0] rc;
    } obs_t;

    localparam logic [7:0] ENC_TBL [16] = '{8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                                            8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};
    localparam logic [7:0] DEC_TBL [16] = '{8'h6A, 8'h35, 8'h97, 8'hC6, 8'h63, 8'hBC, 8'h5E, 8'h2F,
                                            8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h80};

    obs_t q[$];

    neokeon_round_ctrl dut (
        .inClk(inClk), .inRst(inRst), .inStart(inStart), .inDecrypt(inDecrypt),
        .inKeyWr(inKeyWr), .outExtWr(outExtWr), .outIntWr(outIntWr),
        .outIntRC(outIntRC), .outLoadData(outLoadData), .outRoundEn(outRoundEn),
        .outFinal(outFinal), .outRound(outRound), .outDecMode(outDecMode),
        .outBusy(outBusy), .outDone(outDone), .outKeyErr(outKeyErr)
    );

    always #5 inClk = ~inClk;

    function automatic obs_t observe();
        obs_t o;
        o.ext = outExtWr;  o.intwr = outIntWr; o.load = outLoadData;
        o.rnd = outRoundEn; o.fin = outFinal;  o.done = outDone;
        o.busy = outBusy;  o.kerr = outKeyErr; o.decm = outDecMode;
        o.round = outRound; o.rc = outIntRC;
        return o;
    endfunction

    task automatic tick();
        @(posedge inClk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs of one operation: LOAD, 16 x ROUND, FINAL, DONE.
    task automatic push_op(input bit dec, input int kr);
        obs_t e;
        logic [7:0] last;
        last = dec ? DEC_TBL[15] : ENC_TBL[15];
        e = '0; e.intwr = 1; e.load = 1; e.busy = 1; e.decm = dec;
        e.rc = {24'h0, (dec ? 8'hD4 : 8'h80)};
        q.push_back(e);
        for (int k = 0; k < 16; k++) begin
            e = '0; e.intwr = 1; e.rnd = 1; e.busy = 1; e.decm = dec;
            e.round = 5'(k);
            e.rc = {24'h0, (dec ? DEC_TBL[k] : ENC_TBL[k])};
            e.kerr = (kr >= 0 && k == kr + 1);
            q.push_back(e);
        end
        e = '0; e.fin = 1; e.busy = 1; e.decm = dec; e.round = 5'd16;
        e.rc = {24'h0, last}; e.kerr = (kr == 15);
        q.push_back(e);
        e = '0; e.done = 1; e.busy = 1; e.decm = dec; e.round = 5'd16;
        e.rc = {24'h0, last};
        q.push_back(e);
    endtask

    // Called #1 after the start-accept edge; checks n cycles, leaves time in the last one.
    task automatic check_op(input string tag, input int n, input int kr);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            inKeyWr = (kr >= 0 && i == kr + 1);
            #1;
            if (q.size() == 0) begin
                checks++; errors++;
                $error("FAIL %s_queue_empty observed=0 expected=1", tag);
            end else begin
                e = q.pop_front();
                check_vec($sformatf("%s_cyc%0d", tag, i), 64'(observe()), 64'(e));
            end
            if (i < n - 1) tick();
        end
        inKeyWr = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_vec(tag, {61'h0, outBusy, outLoadData, outDone}, 64'h0);
    endtask

    task automatic accept(input bit dec);
        inStart = 1'b1; inDecrypt = dec;
        tick();
        inStart = 1'b0;
    endtask

    initial begin
        obs_t r;
        inRst = 1'b1; inStart = 1'b0; inDecrypt = 1'b0; inKeyWr = 1'b0;
        tick(); tick();
        r = '0; r.rc = 32'h80;
        check_vec("reset_state", 64'(observe()), 64'(r));
        inRst = 1'b0;
        tick();
        check_idle("idle_after_reset");

        // Encrypt: rc 80 then 1B..D4, done on 19th cycle after accept.
        accept(1'b0);
        push_op(1'b0, -1);
        check_op("enc", 19, -1);
        tick();
        check_idle("enc_back_idle");

        // Decrypt request; in an encrypt-only build it must equal the encrypt run.
        accept(1'b1);
        push_op(DEC_EN, -1);
        check_op("dec", 19, -1);
        tick();
        check_idle("dec_back_idle");
        inDecrypt = 1'b0;

        // Key write and start together: key write wins, start taken next cycle.
        inKeyWr = 1'b1; inStart = 1'b1;
        #1;
        check_vec("keywr_start_ext", {61'h0, outExtWr, outBusy, outLoadData}, 64'b100);
        tick();
        inKeyWr = 1'b0;
        #1;
        check_vec("keywr_start_stay_idle", {61'h0, outExtWr, outBusy, outLoadData}, 64'b000);
        tick();
        inStart = 1'b0;
        push_op(1'b0, -1);
        check_op("late_start", 19, -1);
        tick();

        // Key write while busy at round 7.
        accept(1'b0);
        push_op(1'b0, 7);
        check_op("keyerr", 19, 7);
        tick();
        check_idle("keyerr_back_idle");

        // Start held through DONE restarts after one IDLE cycle.
        inStart = 1'b1;
        tick();
        push_op(1'b0, -1);
        check_op("held1", 19, -1);
        tick();
        check_idle("held_idle_gap");
        tick();
        inStart = 1'b0;
        push_op(1'b0, -1);
        check_op("held2", 19, -1);
        tick();

        // Reset at round 9 clears outputs at once and discards the operation.
        accept(1'b0);
        push_op(1'b0, -1);
        check_op("pre_rst", 11, -1);
        #2;
        inRst = 1'b1;
        #1;
        r = '0; r.rc = 32'h80;
        check_vec("async_reset", 64'(observe()), 64'(r));
        q.delete();
        tick(); tick();
        inRst = 1'b0;
        tick();
        check_idle("idle_after_midop_reset");
        accept(1'b0);
        push_op(1'b0, -1);
        check_op("post_rst_enc", 19, -1);
        tick();
        check_idle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
